// File: rtl/rr_decode_sequencer_if.sv
// Request/grant bundle between the requesters and the rr_decode_sequencer that
// drives the 2-to-4 enable decoder (A1A0 = index, EN = enable).
interface rr_decode_sequencer_if;
    logic [3:0] req;
    logic       done;
    logic       A0;
    logic       A1;
    logic       EN;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  A0,
        input  A1,
        input  EN,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output A0,
        output A1,
        output EN,
        output timeout
    );
endinterface

// File: rtl/rr_decode_sequencer.sv
// Four-way round-robin arbiter with break-before-make, feeding a 2-to-4 enable decoder.
// Define RR_TIMEOUT_EN to build the HOLD_MAX hold limit and drive the timeout pulse.
module rr_decode_sequencer #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    rr_decode_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;
    logic       en_q, en_d;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       hit_limit;
    logic       release_now;

    // Rotating priority search starting at ptr, wrapping modulo 4.
    always_comb begin
        pick  = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = bus.done | ~bus.req[idx_q] | hit_limit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    idx_d   = pick;
                    en_d    = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    en_d    = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
        end
    end

`ifdef RR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign hit_limit = (state_q == GRANT) && (cnt_q == CNT_W'(HOLD_MAX));

    // Counts EN=1 cycles of the current grant; the pulse flags a limit-only release.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE && (|bus.req)) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == GRANT) begin
            if (!release_now) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            timeout_d = hit_limit & ~bus.done & bus.req[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^{HOLD_MAX[0], CNT_W[0]};
    assign hit_limit   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.A0 = idx_q[0];
    assign bus.A1 = idx_q[1];
    assign bus.EN = en_q;

endmodule

// File: tb/tb_rr_decode_sequencer.sv
// Randomised plus directed bench for rr_decode_sequencer against a cycle-level reference model.
// Honours RR_TIMEOUT_EN the same way the design does.
module tb_rr_decode_sequencer;

    localparam int HOLD = 4;
`ifdef RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    rr_decode_sequencer_if bus();

    rr_decode_sequencer #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = idle, 1 = granted, 2 = gap.
    int m_mode, m_idx, m_ptr, m_hold;
    bit m_en, m_to;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_en = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        m_to = 0;
        if (m_mode == 0) begin
            if (r != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (r[(m_ptr + k) % 4]) begin
                        m_idx = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_en = 1; m_hold = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (d || !r[m_idx] || (TO_EN && m_hold == HOLD)) begin
                m_to   = TO_EN && !d && r[m_idx] && (m_hold == HOLD);
                m_en   = 0;
                m_ptr  = (m_idx + 1) % 4;
                m_mode = 2;
            end else begin
                m_hold++;
            end
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".EN"}, 32'(bus.EN), 32'(m_en));
        check_val({tag, ".A"}, 32'({bus.A1, bus.A0}), 32'(m_idx));
        check_val({tag, ".TO"}, 32'(bus.timeout), 32'(m_to));
    endtask

    // One clock: inputs applied after the previous edge, outputs checked 1ns after this one.
    task automatic cycle(input logic [3:0] r, input logic d, input string tag);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        if (rst_n) model_step(r, d);
        else model_reset();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input logic [3:0] r);
        bus.req  = r;
        bus.done = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compare_all("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int q_idx[$];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int run;
        bit seen_to;
        bit in_run;
        logic [3:0] r;
        logic       d;

        rst_n    = 1'b1;
        bus.req  = 4'b0;
        bus.done = 1'b0;
        #2;

        // Reset with all requests pending, then idle with none.
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b0, "idle");

        // Single requester 2, done on its third grant cycle, then drop.
        cycle(4'b0100, 1'b0, "g2");
        check_val("g2.first", 32'({bus.EN, bus.A1, bus.A0}), 32'b110);
        cycle(4'b0100, 1'b0, "g2");
        cycle(4'b0100, 1'b1, "g2done");
        check_val("g2.release", 32'(bus.EN), 32'd0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b0, "g2drop");

        // All requesting, done always high: rotation 0,1,2,3,0.
        do_reset(4'b0000);
        for (int i = 0; i < 20 && q_idx.size() < 5; i++) begin
            cycle(4'b1111, 1'b1, "rr");
            if (m_mode == 1 && bus.EN) q_idx.push_back(int'({bus.A1, bus.A0}));
        end
        check_val("rr.count", 32'(q_idx.size()), 32'd5);
        for (int i = 0; i < 5 && i < q_idx.size(); i++) check_val("rr.seq", 32'(q_idx[i]), 32'(exp_seq[i]));

        // Persistent single requester, no done: hold limit or indefinite grant.
        do_reset(4'b0000);
        run = 0; seen_to = 0; in_run = 1;
        for (int i = 0; i < 24; i++) begin
            cycle(4'b0001, 1'b0, "hold");
            if (bus.timeout) seen_to = 1;
            if (bus.EN && in_run) run++;
            else if (run > 0) in_run = 0;
        end
        check_val("hold.run", 32'(run), TO_EN ? 32'(HOLD) : 32'd24);
        check_val("hold.to", 32'(seen_to), 32'(TO_EN));

        // Asynchronous reset mid-grant on index 2, then request 3 from ptr 0.
        do_reset(4'b0000);
        cycle(4'b0100, 1'b0, "pre_arst");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst.EN", 32'(bus.EN), 32'd0);
        check_val("arst.A", 32'({bus.A1, bus.A0}), 32'd0);
        bus.req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1000, 1'b0, "arst_regrant");
        check_val("arst.idx3", 32'({bus.EN, bus.A1, bus.A0}), 32'b111);

        // Random traffic against the model.
        r = 4'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 4) == 0);
            cycle(r, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
